// File: rtl/ofdm_mag_pkg.sv
// Shared constants for the OFDM RX correlation-magnitude stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ofdm_mag_pkg;

    // Magnitude estimator selection, sampled with each input sample
    localparam logic [1:0] MAG_MODE_L1   = 2'b00;  // |Re| + |Im|
    localparam logic [1:0] MAG_MODE_HALF = 2'b01;  // max + min/2
    localparam logic [1:0] MAG_MODE_3_8  = 2'b10;  // max + 3/8 min
    localparam logic [1:0] MAG_MODE_MAX  = 2'b11;  // max only

    // Default geometry: Q7.12 inputs, one guard bit on the magnitude
    localparam int MAG_DATA_W_DFLT  = 20;
    localparam int MAG_MAG_W_DFLT   = 21;
    localparam int MAG_WIN_LEN_DFLT = 160;
    localparam int MAG_IDX_W_DFLT   = 8;

endpackage

// File: rtl/mag_abs_sat.sv
// Saturating absolute value of a two's complement word; most negative input maps to max positive.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module mag_abs_sat
    import ofdm_mag_pkg::*;
#(
    parameter int DATA_W = MAG_DATA_W_DFLT
) (
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-2:0] AbsOut
);

    localparam logic [DATA_W-1:0] ONE     = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] negVal;

    assign negVal = ~DataIn + ONE;

    // Most negative value has no positive counterpart in DATA_W-1 bits, so clamp it
    always_comb begin
        AbsOut = DataIn[DATA_W-2:0];
        if (DataIn == MOST_NEG) begin
            AbsOut = '1;
        end else if (DataIn[DATA_W-1]) begin
            AbsOut = negVal[DATA_W-2:0];
        end
    end

endmodule

// File: rtl/mag_approx_peak_pipe.sv
// Low-cost complex magnitude estimate (L1 / max+min/2 / max+3min/8 / max) with optional per-window peak search.
// Latency: 3 cycles input-to-Magnitude; PeakValid pulses one cycle after the last sample of a window.
// Backpressure: none, one sample per cycle; peak tracker only built when MAG_PEAK_TRACK_EN is defined.
module mag_approx_peak_pipe
    import ofdm_mag_pkg::*;
#(
    parameter int DATA_W  = MAG_DATA_W_DFLT,
    parameter int MAG_W   = MAG_MAG_W_DFLT,
    parameter int WIN_LEN = MAG_WIN_LEN_DFLT,
    parameter int IDX_W   = MAG_IDX_W_DFLT
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              InputEnable,
    input  logic [DATA_W-1:0] DataInRe,
    input  logic [DATA_W-1:0] DataInIm,
    input  logic [1:0]        Mode,
    input  logic              Clear,
    output logic              OutputEnable,
    output logic [MAG_W-1:0]  Magnitude,
    output logic              PeakValid,
    output logic [MAG_W-1:0]  PeakValue,
    output logic [IDX_W-1:0]  PeakIndex
);

    // ---------------- S1: saturating absolute values ----------------
    logic [DATA_W-2:0] absRe;
    logic [DATA_W-2:0] absIm;
    logic [DATA_W-2:0] s1A;
    logic [DATA_W-2:0] s1B;
    logic [1:0]        s1Mode;
    logic              s1Vld;

    mag_abs_sat #(.DATA_W(DATA_W)) uAbsRe (.DataIn(DataInRe), .AbsOut(absRe));
    mag_abs_sat #(.DATA_W(DATA_W)) uAbsIm (.DataIn(DataInIm), .AbsOut(absIm));

    // Register |Re|, |Im| and the mode; idle cycles load zeros so bubbles stay clean
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1A    <= '0;
            s1B    <= '0;
            s1Mode <= '0;
            s1Vld  <= 1'b0;
        end else begin
            s1Vld  <= InputEnable;
            s1A    <= InputEnable ? absRe : '0;
            s1B    <= InputEnable ? absIm : '0;
            s1Mode <= InputEnable ? Mode  : '0;
        end
    end

    // ---------------- S2: sort into max / min ----------------
    logic [DATA_W-2:0] sortMx;
    logic [DATA_W-2:0] sortMn;
    logic [DATA_W-2:0] s2Mx;
    logic [DATA_W-2:0] s2Mn;
    logic [1:0]        s2Mode;
    logic              s2Vld;

    // Order the two magnitudes so S3 only needs shifts and adds
    always_comb begin
        sortMx = s1A;
        sortMn = s1B;
        if (s1B > s1A) begin
            sortMx = s1B;
            sortMn = s1A;
        end
    end

    // Register max/min and carry the per-sample mode forward
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s2Mx   <= '0;
            s2Mn   <= '0;
            s2Mode <= '0;
            s2Vld  <= 1'b0;
        end else begin
            s2Mx   <= sortMx;
            s2Mn   <= sortMn;
            s2Mode <= s1Mode;
            s2Vld  <= s1Vld;
        end
    end

    // ---------------- S3: estimator combine ----------------
    // One extra bit over the operands holds mx+mn, the largest of the four results.
    logic [DATA_W-1:0] mxW;
    logic [DATA_W-1:0] mnW;
    logic [DATA_W-1:0] estSum;

    assign mxW = {1'b0, s2Mx};
    assign mnW = {1'b0, s2Mn};

    // Select the estimator; shifts truncate toward zero
    always_comb begin
        estSum = mxW;
        case (s2Mode)
            MAG_MODE_L1:   estSum = mxW + mnW;
            MAG_MODE_HALF: estSum = mxW + (mnW >> 1);
            MAG_MODE_3_8:  estSum = mxW + (mnW >> 2) + (mnW >> 3);
            MAG_MODE_MAX:  estSum = mxW;
            default:       estSum = mxW;
        endcase
    end

    // Output register; Magnitude is forced to zero on idle cycles
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            OutputEnable <= 1'b0;
            Magnitude    <= '0;
        end else begin
            OutputEnable <= s2Vld;
            Magnitude    <= s2Vld ? {{(MAG_W-DATA_W){1'b0}}, estSum} : '0;
        end
    end

`ifdef MAG_PEAK_TRACK_EN
    // ---------------- Peak tracker over WIN_LEN valid outputs ----------------
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] runIdx;
    logic [MAG_W-1:0] runMax;
    logic [IDX_W-1:0] candIdx;
    logic [MAG_W-1:0] candMax;
    logic             pkVld;
    logic [MAG_W-1:0] pkVal;
    logic [IDX_W-1:0] pkIdx;

    // Running best including the current sample; strict > keeps the first of equal peaks
    always_comb begin
        candMax = runMax;
        candIdx = runIdx;
        if ((cnt == '0) || (Magnitude > runMax)) begin
            candMax = Magnitude;
            candIdx = cnt;
        end
    end

    // Window counter and peak registers; Clear wins over a coincident window end
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt    <= '0;
            runMax <= '0;
            runIdx <= '0;
            pkVld  <= 1'b0;
            pkVal  <= '0;
            pkIdx  <= '0;
        end else begin
            pkVld <= 1'b0;
            if (Clear) begin
                if (OutputEnable) begin
                    // The coincident sample opens the new window at index 0
                    runMax <= Magnitude;
                    runIdx <= '0;
                    cnt    <= IDX_ONE;
                end else begin
                    runMax <= '0;
                    runIdx <= '0;
                    cnt    <= '0;
                end
            end else if (OutputEnable) begin
                if (cnt == LAST_IDX) begin
                    pkVld  <= 1'b1;
                    pkVal  <= candMax;
                    pkIdx  <= candIdx;
                    cnt    <= '0;
                    runMax <= '0;
                    runIdx <= '0;
                end else begin
                    cnt    <= cnt + IDX_ONE;
                    runMax <= candMax;
                    runIdx <= candIdx;
                end
            end
        end
    end

    assign PeakValid = pkVld;
    assign PeakValue = pkVal;
    assign PeakIndex = pkIdx;
`else
    // Tracker not built: peak outputs idle and Clear has no effect
    logic unusedClear;
    assign unusedClear = Clear;
    assign PeakValid   = 1'b0;
    assign PeakValue   = '0;
    assign PeakIndex   = '0;
`endif

endmodule

// File: tb/tb_mag_approx_peak_pipe.sv
// Bench for mag_approx_peak_pipe: directed vectors, expected results queued at issue time.
// Latency: expectations are stamped with issue cycle + 3 (Magnitude) and last-sample cycle + 4 (PeakValid).
// Backpressure: none; a monitor pops and compares whenever OutputEnable or PeakValid is seen.
module tb_mag_approx_peak_pipe;

    localparam int DATA_W  = 20;
    localparam int MAG_W   = 21;
    localparam int WIN_LEN = 160;
    localparam int IDX_W   = 8;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              InputEnable = 1'b0;
    logic [DATA_W-1:0] DataInRe = '0;
    logic [DATA_W-1:0] DataInIm = '0;
    logic [1:0]        Mode = 2'b00;
    logic              Clear = 1'b0;
    logic              OutputEnable;
    logic [MAG_W-1:0]  Magnitude;
    logic              PeakValid;
    logic [MAG_W-1:0]  PeakValue;
    logic [IDX_W-1:0]  PeakIndex;

    mag_approx_peak_pipe #(
        .DATA_W (DATA_W),
        .MAG_W  (MAG_W),
        .WIN_LEN(WIN_LEN),
        .IDX_W  (IDX_W)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .InputEnable (InputEnable),
        .DataInRe    (DataInRe),
        .DataInIm    (DataInIm),
        .Mode        (Mode),
        .Clear       (Clear),
        .OutputEnable(OutputEnable),
        .Magnitude   (Magnitude),
        .PeakValid   (PeakValid),
        .PeakValue   (PeakValue),
        .PeakIndex   (PeakIndex)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [MAG_W-1:0] mag;
    } magExp_t;

    typedef struct {
        int               cyc;
        logic [MAG_W-1:0] val;
        logic [IDX_W-1:0] idx;
    } peakExp_t;

    magExp_t  magQ[$];
    peakExp_t peakQ[$];

    int nVec  = 0;
    int nFail = 0;
    int lastIssue = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flagUnexpected(input string name);
        nVec++;
        nFail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Apply one sample in the current cycle; optionally queue its expected magnitude
    task automatic drive(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                         input logic [1:0] md, input logic [MAG_W-1:0] expMag, input bit push);
        InputEnable = 1'b1;
        DataInRe    = re;
        DataInIm    = im;
        Mode        = md;
        lastIssue   = cyc;
        if (push) magQ.push_back('{cyc + 3, expMag});
    endtask

    task automatic idleInputs();
        InputEnable = 1'b0;
        DataInRe    = '0;
        DataInIm    = '0;
        Mode        = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            idleInputs();
        end
    endtask

    task automatic sendOne(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                           input logic [1:0] md, input logic [MAG_W-1:0] expMag);
        @(negedge Clk);
        drive(re, im, md, expMag, 1'b1);
    endtask

    task automatic pushPeak(input logic [MAG_W-1:0] val, input logic [IDX_W-1:0] idx);
`ifdef MAG_PEAK_TRACK_EN
        peakQ.push_back('{lastIssue + 4, val, idx});
`else
        if (val == '1 && idx == '1) peakQ.push_back('{0, val, idx});
`endif
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    endtask

    // Monitor: compare every presented output against the head of its queue
    initial begin
        magExp_t  me;
        peakExp_t pe;
        forever begin
            @(posedge Clk);
            #1;
            if (PeakValid) begin
                if (peakQ.size() == 0) begin
                    flagUnexpected("peak_valid");
                end else begin
                    pe = peakQ.pop_front();
                    check("peak_value", PeakValue, pe.val);
                    check("peak_index", PeakIndex, pe.idx);
                    check("peak_cycle", cyc, pe.cyc);
                end
            end
            if (OutputEnable) begin
                if (magQ.size() == 0) begin
                    flagUnexpected("output_enable");
                end else begin
                    me = magQ.pop_front();
                    check("magnitude", Magnitude, me.mag);
                    check("mag_cycle", cyc, me.cyc);
                end
            end else if (Magnitude != '0) begin
                check("idle_magnitude", Magnitude, 0);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        nFail++;
        summary();
        $fatal(1, "watchdog");
    end

    // Expected magnitudes for Re=-3.0, Im=4.0 by mode
    logic [MAG_W-1:0] modeExp [4];

    initial begin
        logic [DATA_W-1:0] v;
        modeExp[0] = 21'd28672;
        modeExp[1] = 21'd22528;
        modeExp[2] = 21'd20992;
        modeExp[3] = 21'd16384;

        // Reset state
        Rst_n = 1'b1;
        #2 Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_oe",      OutputEnable, 0);
        check("rst_mag",     Magnitude, 0);
        check("rst_pkvld",   PeakValid, 0);
        check("rst_pkval",   PeakValue, 0);
        check("rst_pkidx",   PeakIndex, 0);
        Rst_n = 1'b1;
        idle(2);

        // Each mode on a single isolated sample
        for (int m = 0; m < 4; m++) begin
            sendOne(20'hFD000, 20'h04000, 2'(m), modeExp[m]);
            idle(3);
        end

        // Saturation and truncation corners
        sendOne(20'h80000, 20'h00000, 2'b00, 21'h07FFFF);
        sendOne(20'h80000, 20'h80000, 2'b00, 21'h0FFFFE);
        sendOne(20'hFFFFF, 20'h00002, 2'b11, 21'd2);
        sendOne(20'h00003, 20'hFFFFB, 2'b01, 21'd6);
        sendOne(20'h00007, 20'hFFFF8, 2'b10, 21'd9);
        idle(4);

        // Eight back-to-back samples, mode changing every cycle, operands swapped on odd samples
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) sendOne(20'hFD000, 20'h04000, 2'(i % 4), modeExp[i % 4]);
            else            sendOne(20'h04000, 20'hFD000, 2'(i % 4), modeExp[i % 4]);
        end
        idle(5);

        // Restart the window so the peak tests begin at index 0
        @(negedge Clk);
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        idle(2);

        // Window with peak 5000 at index 37 and an equal value at index 90
        for (int k = 0; k < WIN_LEN; k++) begin
            if (k == 37 || k == 90) v = 20'd5000;
            else if (k < 37)        v = DATA_W'(100 * k + 1300);
            else                    v = DATA_W'(4000 - k);
            sendOne(v, 20'd0, 2'b11, MAG_W'(v));
        end
        pushPeak(21'd5000, 8'd37);
        idle(6);

        // Clear together with output 50: old window discarded, new one runs 160 samples from there
        for (int i = 0; i < 213; i++) begin
            @(negedge Clk);
            Clear = (i == 53);
            if (i < 210) begin
                if (i < 50)        v = 20'd7000;
                else if (i == 120) v = 20'd6000;
                else               v = 20'd2000;
                drive(v, 20'd0, 2'b11, MAG_W'(v), 1'b1);
            end else begin
                idleInputs();
            end
            if (i == 209) pushPeak(21'd6000, 8'd70);
        end
        @(negedge Clk);
        Clear = 1'b0;
        idle(6);

        // Partial window, then reset with two samples still in the pipe
        for (int k = 0; k < 30; k++) sendOne(20'd9000, 20'd0, 2'b11, 21'd9000);
        idle(5);
        @(negedge Clk);
        drive(20'd1111, 20'd0, 2'b11, '0, 1'b0);
        @(negedge Clk);
        drive(20'd2222, 20'd0, 2'b11, '0, 1'b0);
        @(negedge Clk);
        idleInputs();
        Rst_n = 1'b0;
        #1;
        check("arst_oe",    OutputEnable, 0);
        check("arst_mag",   Magnitude, 0);
        check("arst_pkvld", PeakValid, 0);
        check("arst_pkval", PeakValue, 0);
        check("arst_pkidx", PeakIndex, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        idle(2);

        // Fresh window after reset must start at index 0
        for (int k = 0; k < WIN_LEN; k++) begin
            v = (k == 5) ? 20'd3000 : 20'd100;
            sendOne(v, 20'd0, 2'b11, MAG_W'(v));
        end
        pushPeak(21'd3000, 8'd5);
        idle(10);

        // Peak result holds after the window closes
`ifdef MAG_PEAK_TRACK_EN
        check("hold_pkval", PeakValue, 3000);
        check("hold_pkidx", PeakIndex, 5);
`else
        check("tied_pkval", PeakValue, 0);
        check("tied_pkidx", PeakIndex, 0);
`endif
        check("mag_queue_empty",  magQ.size(), 0);
        check("peak_queue_empty", peakQ.size(), 0);

        summary();
        $finish;
    end

endmodule
